// File: rtl/mem_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_resp_pkg                                                |
// | Description : Shared types and constants for the memory responder:       |
// |               FSM state encoding, grant identifiers, index-width helper. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package mem_resp_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Port identifiers used by the arbiter and the captured grant
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Number of word-index bits for an array of 'depth' words
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_rr_arbiter                                             |
// | Description : Two-way round-robin arbiter between the fetch and data     |
// |               ports. On a tie the port not granted last wins.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_rr_arbiter
    import mem_resp_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_sel_o
);

    // Pick a single requester; alternate when both are pending
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_sel_o   = GRANT_I;
        if (i_req_i && d_req_i) begin
            grant_sel_o = (last_grant_i == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req_i) begin
            grant_sel_o = GRANT_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_responder                                              |
// | Description : Single-ported word memory serving a fetch port and a data  |
// |               port with a req/valid handshake, programmable wait states  |
// |               and round-robin arbitration.                               |
// |               Optional macro MEM_ALIGN_CHK_EN: misaligned requests       |
// |               complete with err=1, rdata=0 and writes suppressed.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_err
);

    localparam int         IDX_W       = idx_w(DEPTH);
    // WAIT spans WAIT_CYCLES+1 cycles so that the array access lands on
    // edge E0+WAIT_CYCLES+1, giving a WAIT_CYCLES+3 cycle transaction period.
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               sel_q;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic               mis_q;
    logic [31:0]        mem_q [DEPTH];

    logic               i_valid_q, d_valid_q, i_err_q, d_err_q;
    logic [31:0]        i_rdata_q, d_rdata_q;

    logic               grant_valid_w, grant_sel_w;
    logic               capture_w, enter_resp_w;
    logic [ADDR_W-1:0]  sel_addr_w;
    logic               mis_w;
    logic               w_unused_bits;

    mem_rr_arbiter u_arb (
        .i_req_i       (i_req),
        .d_req_i       (d_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid_w),
        .grant_sel_o   (grant_sel_w)
    );

    assign sel_addr_w = (grant_sel_w == GRANT_D) ? d_addr : i_addr;

`ifdef MEM_ALIGN_CHK_EN
    assign mis_w = (sel_addr_w[1:0] != 2'b00);
`else
    assign mis_w = 1'b0;
`endif

    // Address bits outside the word index do not select storage
    assign w_unused_bits = ^{i_addr[ADDR_W-1:IDX_W+2], i_addr[1:0],
                             d_addr[ADDR_W-1:IDX_W+2], d_addr[1:0]};

    // Next-state logic: grant in IDLE, count down in WAIT, single-cycle RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        capture_w    = 1'b0;
        enter_resp_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid_w) begin
                    capture_w    = 1'b1;
                    last_grant_d = grant_sel_w;
                    cnt_d        = C_WAIT_LOAD;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp_w = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, counter and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Capture the granted request so requesters may change inputs later
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= GRANT_I;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else if (capture_w) begin
            sel_q   <= grant_sel_w;
            idx_q   <= sel_addr_w[IDX_W+1:2];
            we_q    <= (grant_sel_w == GRANT_D) ? d_we : 1'b0;
            wdata_q <= d_wdata;
            mis_q   <= mis_w;
        end
    end

    // Array write on the edge entering RESP; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_w && we_q && !mis_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Response registers: only the granted port's outputs change
    always_ff @(posedge clk) begin
        if (rst) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            i_valid_q <= enter_resp_w && (sel_q == GRANT_I);
            d_valid_q <= enter_resp_w && (sel_q == GRANT_D);
            i_err_q   <= enter_resp_w && (sel_q == GRANT_I) && mis_q;
            d_err_q   <= enter_resp_w && (sel_q == GRANT_D) && mis_q;
            if (enter_resp_w && (!we_q || mis_q)) begin
                if (sel_q == GRANT_D) begin
                    d_rdata_q <= mis_q ? 32'd0 : mem_q[idx_q];
                end else begin
                    i_rdata_q <= mis_q ? 32'd0 : mem_q[idx_q];
                end
            end
        end
    end

    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_responder                                           |
// | Description : Scoreboard bench for mem_responder: requester tasks push   |
// |               request descriptors, a negedge monitor pops and checks     |
// |               them against a word-array reference model.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;
    localparam int AW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   d_wdata, i_rdata, d_rdata;
    logic          i_valid, d_valid, i_err, d_err;

    logic          z_i_req, z_d_req, z_d_we;
    logic [AW-1:0] z_i_addr, z_d_addr;
    logic [31:0]   z_d_wdata, z_i_rdata, z_d_rdata;
    logic          z_i_valid, z_d_valid, z_i_err, z_d_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dv_cnt = 0;

    req_t        iq[$];
    req_t        dq[$];
    int          ord_q[$];
    int          ord_cyc[$];
    logic [31:0] model [DEPTH];
    logic [31:0] i_last, d_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err)
    );

    mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_valid(z_i_valid), .i_err(z_i_err),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_rdata(z_d_rdata), .d_valid(z_d_valid), .d_err(z_d_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[$clog2(DEPTH)+1:2]);
    endfunction

    function automatic logic misal(input logic [31:0] a);
`ifdef MEM_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one completion at a time, model updated in completion order
    always @(negedge clk) begin : mon
        req_t        r;
        logic [31:0] e;
        logic        m;
        if (rst) begin
            i_last = 32'd0;
            d_last = 32'd0;
        end else begin
            if (i_valid || d_valid)
                chk("one_valid_at_a_time", 32'(i_valid && d_valid), 32'd0);
            if (d_valid) begin
                dv_cnt++;
                ord_q.push_back(1);
                ord_cyc.push_back(cyc);
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_unexpected_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    r = dq.pop_front();
                    m = misal(r.addr);
                    if (r.we) begin
                        if (!m) model[widx(r.addr)] = r.wdata;
                        e = m ? 32'd0 : d_last;
                    end else begin
                        e = m ? 32'd0 : model[widx(r.addr)];
                    end
                    chk("d_rdata", d_rdata, e);
                    chk("d_err", 32'(d_err), 32'(m));
                    chk("i_rdata_hold", i_rdata, i_last);
                    d_last = e;
                end
            end
            if (i_valid) begin
                ord_q.push_back(0);
                ord_cyc.push_back(cyc);
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL i_unexpected_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    r = iq.pop_front();
                    m = misal(r.addr);
                    e = m ? 32'd0 : model[widx(r.addr)];
                    chk("i_rdata", i_rdata, e);
                    chk("i_err", 32'(i_err), 32'(m));
                    chk("d_rdata_hold", d_rdata, d_last);
                    i_last = e;
                end
            end
        end
    end

    // Data requester: call at posedge+1; returns at the negedge where d_valid is seen
    task automatic d_access(input logic [31:0] a, input logic we, input logic [31:0] wd, output int lat);
        int t0;
        bit got;
        d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        dq.push_back('{a, we, wd});
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (d_valid) got = 1'b1;
        end
        d_req = 1'b0;
        lat   = cyc - t0;
        if (!got) chk("d_timeout", 32'd0, 32'd1);
    endtask

    task automatic i_access(input logic [31:0] a, output int lat);
        int t0;
        bit got;
        i_req = 1'b1; i_addr = a;
        iq.push_back('{a, 1'b0, 32'd0});
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (i_valid) got = 1'b1;
        end
        i_req = 1'b0;
        lat   = cyc - t0;
        if (!got) chk("i_timeout", 32'd0, 32'd1);
    endtask

    task automatic z_wait(output int at);
        bit got;
        got = 1'b0;
        at  = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (z_d_valid) begin got = 1'b1; at = cyc; end
        end
        if (!got) chk("z_timeout", 32'd0, 32'd1);
    endtask

    // Abort a write to 0x20 with reset asserted on edge E0+rst_edge
    task automatic abort_write(input int rst_edge);
        int pre;
        pre = dv_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55555555;
        for (int k = 0; k < rst_edge; k++) sync();
        rst = 1'b1; d_req = 1'b0;
        sync(); sync();
        rst = 1'b0;
        repeat (6) sync();
        chk("abort_no_valid", 32'(dv_cnt - pre), 32'd0);
    endtask

    initial begin
        int lat_d, lat_i, lat, base, t1, t2;
        logic [31:0] w10;
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int lat_d, lat_i, lat, base, t1, t2;
        logic [31:0] w10;
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_i_err",   32'(i_err),   32'd0);
        chk("rst_d_err",   32'(d_err),   32'd0);
        chk("rst_i_rdata", i_rdata,      32'd0);
        chk("rst_d_rdata", d_rdata,      32'd0);
        sync();
        rst = 1'b0;
        sync();

        // Tie after reset: data first, fetch next; fetch sees the new data
        fork
            d_access(32'h40, 1'b1, 32'hCAFE0040, lat_d);
            i_access(32'h40, lat_i);
        join
        chk("tie_d_latency", 32'(lat_d), 32'(W + 2));
        chk("tie_i_latency", 32'(lat_i), 32'(2 * W + 5));
        chk("raw_fetch_data", i_rdata, 32'hCAFE0040);
        sync();

        // Both held for four transactions: D,I,D,I spaced one period apart
        base = ord_q.size();
        fork
            begin
                for (int n = 0; n < 2; n++) begin
                    d_access(32'h44 + 32'(4 * n), 1'b1, $urandom, lat);
                    sync();
                end
            end
            begin
                for (int n = 0; n < 2; n++) begin
                    i_access(32'h40, lat);
                    sync();
                end
            end
        join
        if (ord_q.size() < base + 4) begin
            chk("rr_count", 32'(ord_q.size() - base), 32'd4);
        end else begin
            for (int j = 0; j < 4; j++) begin
                chk("rr_order", 32'(ord_q[base + j]), 32'((j % 2 == 0) ? 1 : 0));
                if (j > 0) chk("rr_period", 32'(ord_cyc[base + j] - ord_cyc[base + j - 1]), 32'(W + 3));
            end
        end
        sync();

        // Write then read
        d_access(32'h10, 1'b1, 32'hDEADBEEF, lat);
        chk("wr_latency", 32'(lat), 32'(W + 2));
        sync();
        d_access(32'h10, 1'b0, 32'd0, lat);
        chk("rd_after_wr", d_rdata, 32'hDEADBEEF);
        sync();

        // Fill the whole array so every later read has a defined value
        for (int a = 0; a < DEPTH; a++) begin
            d_access(32'(a * 4), 1'b1, $urandom, lat);
            sync();
        end

        // Aliasing modulo DEPTH*4
        d_access(32'h400, 1'b1, 32'h12345678, lat);
        sync();
        d_access(32'h000, 1'b0, 32'd0, lat);
        chk("alias_read", d_rdata, 32'h12345678);
        sync();

        // Misaligned write
        w10 = model[4];
        d_access(32'h13, 1'b1, 32'h5, lat);
`ifdef MEM_ALIGN_CHK_EN
        chk("misal_err", 32'(d_err), 32'd1);
`else
        chk("misal_err", 32'(d_err), 32'd0);
`endif
        sync();
        i_access(32'h10, lat);
`ifdef MEM_ALIGN_CHK_EN
        chk("misal_word", i_rdata, w10);
`else
        chk("misal_word", i_rdata, 32'h5);
`endif
        sync();

        // Randomized concurrent traffic
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    d_access($urandom, 1'($urandom_range(0, 1)), $urandom, lat_d);
                    chk("rand_d_latency", 32'(lat_d >= W + 2 && lat_d <= 2 * W + 5), 32'd1);
                    sync();
                    repeat ($urandom_range(0, 3)) sync();
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    i_access($urandom, lat_i);
                    chk("rand_i_latency", 32'(lat_i >= W + 2 && lat_i <= 2 * W + 5), 32'd1);
                    sync();
                    repeat ($urandom_range(0, 3)) sync();
                end
            end
        join
        sync();

        // Reset in WAIT and reset on the RESP-entry edge both drop the write
        d_access(32'h20, 1'b1, 32'hAAAA0000, lat);
        sync();
        abort_write(2);
        chk("rst_again_d_rdata", d_rdata, 32'd0);
        d_access(32'h20, 1'b0, 32'd0, lat);
        chk("abort_wait_word", d_rdata, 32'hAAAA0000);
        sync();
        abort_write(W + 1);
        d_access(32'h20, 1'b0, 32'd0, lat);
        chk("abort_edge_word", d_rdata, 32'hAAAA0000);
        sync();

        // Zero wait states: latency and back-to-back period
        z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h8; z_d_wdata = 32'h0BADF00D;
        t1 = cyc;
        z_wait(t2);
        chk("w0_wr_latency", 32'(t2 - t1), 32'd2);
        z_d_req = 1'b0;
        sync();
        z_d_req = 1'b1; z_d_we = 1'b0;
        t1 = cyc;
        z_wait(t2);
        chk("w0_rd_latency", 32'(t2 - t1), 32'd2);
        chk("w0_rd_data", z_d_rdata, 32'h0BADF00D);
        t1 = t2;
        z_wait(t2);
        chk("w0_period", 32'(t2 - t1), 32'd3);
        z_d_req = 1'b0;
        chk("w0_fetch_idle", 32'(z_i_valid | z_i_err), 32'd0);
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
